pc_hazard_ctrl: RTL and testbench
=================================

Name: pc_hazard_ctrl

Overview:
- Consumer of the decoded control word in the 5-stage MIPS pipeline. Owns the PC register.
- Resolves jumps and branches in the ID stage, and detects load-use and branch-operand data hazards.
- Drives IF/ID write-enable, IF/ID flush and ID/EX bubble.
- Keeps small EX/MEM shadow trackers of destination registers, plus saturating stall/flush performance counters.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Jump  in  1  decoded J from the ID-stage control unit.
- Jal  in  1  decoded JAL.
- Jr  in  1  decoded JR.
- BranchEQ  in  1  decoded BEQ.
- BranchNE  in  1  decoded BNE.
- id_mem_read  in  1  MemRead of the ID instruction.
- id_reg_write  in  1  RegWrite of the ID instruction.
- id_dst  in  5  final destination register of the ID instruction (after RegDst/Jal mux).
- id_rs  in  5  rs field.
- id_rt  in  5  rt field.
- id_uses_rt  in  1  ID instruction reads rt (R-type, SW, BEQ/BNE).
- id_pc4  in  32  PC+4 of the ID instruction.
- id_imm16  in  16  immediate field.
- id_jaddr  in  26  jump index field.
- rs_data  in  32  forwarded rs value in ID.
- rt_data  in  32  forwarded rt value in ID.
- pc  out  32  current fetch address (registered).
- if_id_write  out  1  IF/ID register load enable.
- if_id_flush  out  1  zero IF/ID on the next edge.
- id_ex_bubble  out  1  load NOP control into ID/EX.
- jr_misalign  out  1  registered 1-cycle pulse: JR target[1:0] != 0.
- stall_cnt  out  CNT_W  stall cycles, saturating.
- flush_cnt  out  CNT_W  redirects, saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - pc = RESET_PC; all trackers, counters and jr_misalign = 0.
  - While reset is high: if_id_write = 0, if_id_flush = 1, id_ex_bubble = 1.
- Trackers:
  - ex_{mem_read, reg_write, dst} load from the id_* inputs each edge, or load zeros when id_ex_bubble = 1.
  - mem_{mem_read, dst} load from the ex_* trackers.
  - A dst of 0 never matches any source register.
- Stall (combinational, same cycle). Stall when any of the following holds:
  - (a) Load-use: ex_mem_read && ex_dst != 0 && (ex_dst == id_rs || (id_uses_rt && ex_dst == id_rt)).
  - (b) Branch or Jr operand produced by an EX instruction: (BranchEQ|BranchNE|Jr) && ex_reg_write && match, with the same match rule as (a) (rt only for branches).
  - (c) Branch or Jr operand produced by a load in MEM: (BranchEQ|BranchNE|Jr) && mem_mem_read && match.
- On stall:
  - pc holds; if_id_write = 0; id_ex_bubble = 1; if_id_flush = 0.
  - Redirect is suppressed that cycle.
  - stall_cnt increments.
- Redirect (only when not stalled). taken = Jump | Jal | Jr | (BranchEQ && rs_data == rt_data) | (BranchNE && rs_data != rt_data).
  - Targets:
    - J/JAL: {id_pc4[31:28], id_jaddr, 2'b00}.
    - JR: {rs_data[31:2], 2'b00}.
    - Branch: id_pc4 + (sext(id_imm16) << 2), mod 2^32.
  - Priority among targets if several flags are set: Jr > Jump/Jal > branch.
  - When taken: pc <= target; if_id_flush = 1; if_id_write = 1; flush_cnt increments.
  - JR with rs_data[1:0] != 0: jr_misalign pulses for exactly 1 cycle after the edge.
- Sequential (no stall, no redirect): pc <= pc + 4, wrapping at 2^32; if_id_write = 1; flush and bubble = 0.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-redirect: everything returns to reset values immediately. No pending redirect survives reset.
- Latency:
  - Redirect costs 1 flushed slot.
  - Load-use costs 1 bubble.
  - Branch on an ALU result costs 1 stall; branch on a load result costs 2 stalls.

Test Plan:
- Reset, then 3 clean cycles with no control flags -> pc = 0x00400000, then 0x00400004, 0x00400008, 0x0040000C; if_id_write = 1; all counters 0.
- LW dst = 8 in ID, next cycle ADD with rs = 8 -> exactly 1 cycle with id_ex_bubble = 1, if_id_write = 0, pc held; stall_cnt = 1; next cycle resumes pc + 4.
- BEQ with rs_data = rt_data = 5, id_pc4 = 0x00400010, imm = 0xFFFE -> next pc = 0x00400008; if_id_flush = 1 for 1 cycle; flush_cnt = 1. Same setup with BNE -> not taken, pc + 4.
- LW dst = 9 immediately followed by BEQ rs = 9 -> 2 stall cycles, then branch resolves; stall_cnt = 2; flush_cnt = 1 if taken.
- JR with rs_data = 0x00400033 -> pc = 0x00400030; jr_misalign is a 1-cycle pulse. JAL with jaddr = 0x0100010, id_pc4 = 0x00400004 -> pc = 0x00400040.
- Stall every cycle for 2^CNT_W + 3 cycles -> stall_cnt holds at 0xFFFF. Assert reset mid-stall -> pc = RESET_PC and counters = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_hazard_ctrl.sv
// PC owner and hazard controller for the 5-stage MIPS pipeline: resolves jumps/branches in ID,
// detects load-use and control-operand hazards, and keeps saturating stall/flush counters.
module pc_hazard_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Jump,
    input  logic             Jal,
    input  logic             Jr,
    input  logic             BranchEQ,
    input  logic             BranchNE,
    input  logic             id_mem_read,
    input  logic             id_reg_write,
    input  logic [4:0]       id_dst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [31:0]      id_pc4,
    input  logic [15:0]      id_imm16,
    input  logic [25:0]      id_jaddr,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic [31:0]      pc,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             jr_misalign,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    // Shadow copies of the destination info of the instructions in EX and MEM.
    logic       ex_mem_read;
    logic       ex_reg_write;
    logic [4:0] ex_dst;
    logic       mem_mem_read;
    logic [4:0] mem_dst;

    logic        is_branch;
    logic        ctl_reads_reg;
    logic        load_use;
    logic        ex_ctl_haz;
    logic        mem_ctl_haz;
    logic        stall;
    logic        br_taken;
    logic        taken;
    logic [31:0] br_offset;
    logic [31:0] target;
    logic [31:0] pc_d;

    // Register 0 is hardwired, so a zero destination never creates a dependency.
    function automatic logic src_match(input logic [4:0] dst, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic use_rt);
        return (dst != 5'd0) && ((dst == rs) || (use_rt && (dst == rt)));
    endfunction

    always_comb begin
        is_branch     = BranchEQ | BranchNE;
        ctl_reads_reg = is_branch | Jr;

        load_use    = ex_mem_read && src_match(ex_dst, id_rs, id_rt, id_uses_rt);
        // JR reads only rs; branches compare rs against rt.
        ex_ctl_haz  = ctl_reads_reg && ex_reg_write && src_match(ex_dst, id_rs, id_rt, is_branch);
        mem_ctl_haz = ctl_reads_reg && mem_mem_read && src_match(mem_dst, id_rs, id_rt, is_branch);
        stall       = load_use | ex_ctl_haz | mem_ctl_haz;

        br_taken = (BranchEQ && (rs_data == rt_data)) || (BranchNE && (rs_data != rt_data));
        taken    = !stall && (Jump | Jal | Jr | br_taken);
    end

    always_comb begin
        br_offset = {{14{id_imm16[15]}}, id_imm16, 2'b00};
        if (Jr) begin
            target = {rs_data[31:2], 2'b00};
        end else if (Jump || Jal) begin
            target = {id_pc4[31:28], id_jaddr, 2'b00};
        end else begin
            target = id_pc4 + br_offset;
        end
    end

    always_comb begin
        pc_d = pc + 32'd4;
        if (stall) begin
            pc_d = pc;
        end else if (taken) begin
            pc_d = target;
        end
    end

    always_comb begin
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (reset) begin
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (stall) begin
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            if_id_flush = taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_dst       <= 5'd0;
            mem_mem_read <= 1'b0;
            mem_dst      <= 5'd0;
            jr_misalign  <= 1'b0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            pc <= pc_d;
            if (stall) begin
                ex_mem_read  <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_dst       <= 5'd0;
            end else begin
                ex_mem_read  <= id_mem_read;
                ex_reg_write <= id_reg_write;
                ex_dst       <= id_dst;
            end
            mem_mem_read <= ex_mem_read;
            mem_dst      <= ex_dst;
            jr_misalign  <= !stall && Jr && (rs_data[1:0] != 2'b00);
            if (stall && (stall_cnt != CntMax)) begin
                stall_cnt <= stall_cnt + CntOne;
            end
            if (taken && (flush_cnt != CntMax)) begin
                flush_cnt <= flush_cnt + CntOne;
            end
        end
    end

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Directed table-driven bench for pc_hazard_ctrl; narrow counters so saturation is reachable.
module tb_pc_hazard_ctrl;

    localparam int unsigned CW = 8;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    typedef struct {
        logic        jump, jal, jr, beq, bne, mr, rw, urt;
        logic [4:0]  dst, rs, rt;
        logic [31:0] pc4, rsd, rtd;
        logic [15:0] imm;
        logic [25:0] jaddr;
        logic [31:0] e_pc;
        logic        e_wr, e_fl, e_bb, e_mis;
        logic [CW-1:0] e_sc, e_fc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic Jump, Jal, Jr, BranchEQ, BranchNE;
    logic id_mem_read, id_reg_write, id_uses_rt;
    logic [4:0] id_dst, id_rs, id_rt;
    logic [31:0] id_pc4, rs_data, rt_data;
    logic [15:0] id_imm16;
    logic [25:0] id_jaddr;
    logic [31:0] pc;
    logic if_id_write, if_id_flush, id_ex_bubble, jr_misalign;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    vec_t tv[$];

    pc_hazard_ctrl #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Jump(Jump), .Jal(Jal), .Jr(Jr),
        .BranchEQ(BranchEQ), .BranchNE(BranchNE), .id_mem_read(id_mem_read),
        .id_reg_write(id_reg_write), .id_dst(id_dst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_pc4(id_pc4), .id_imm16(id_imm16), .id_jaddr(id_jaddr),
        .rs_data(rs_data), .rt_data(rt_data), .pc(pc), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .jr_misalign(jr_misalign),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t v_idle();
        vec_t v;
        v.jump = 0; v.jal = 0; v.jr = 0; v.beq = 0; v.bne = 0; v.mr = 0; v.rw = 0; v.urt = 0;
        v.dst = 0; v.rs = 0; v.rt = 0; v.pc4 = 0; v.rsd = 0; v.rtd = 0; v.imm = 0; v.jaddr = 0;
        v.e_pc = 0; v.e_wr = 0; v.e_fl = 0; v.e_bb = 0; v.e_mis = 0; v.e_sc = 0; v.e_fc = 0;
        return v;
    endfunction

    function automatic vec_t v_lw(input logic [4:0] dst);
        vec_t v = v_idle();
        v.mr = 1; v.rw = 1; v.dst = dst;
        return v;
    endfunction

    function automatic vec_t v_alu(input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] dst);
        vec_t v = v_idle();
        v.rw = 1; v.urt = 1; v.rs = rs; v.rt = rt; v.dst = dst;
        return v;
    endfunction

    function automatic vec_t v_br(input logic ne, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [31:0] rsd, input logic [31:0] rtd,
                                  input logic [31:0] pc4, input logic [15:0] imm);
        vec_t v = v_idle();
        v.beq = !ne; v.bne = ne; v.urt = 1; v.rs = rs; v.rt = rt;
        v.rsd = rsd; v.rtd = rtd; v.pc4 = pc4; v.imm = imm;
        return v;
    endfunction

    function automatic vec_t v_jr(input logic [4:0] rs, input logic [31:0] rsd);
        vec_t v = v_idle();
        v.jr = 1; v.rs = rs; v.rsd = rsd;
        return v;
    endfunction

    function automatic vec_t v_jal(input logic [25:0] jaddr, input logic [31:0] pc4);
        vec_t v = v_idle();
        v.jal = 1; v.rw = 1; v.dst = 5'd31; v.jaddr = jaddr; v.pc4 = pc4;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t vi, input logic [31:0] p, input logic wr,
                                input logic fl, input logic bb, input logic mis,
                                input logic [CW-1:0] sc, input logic [CW-1:0] fc);
        vec_t v = vi;
        v.e_pc = p; v.e_wr = wr; v.e_fl = fl; v.e_bb = bb; v.e_mis = mis;
        v.e_sc = sc; v.e_fc = fc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Jump = v.jump; Jal = v.jal; Jr = v.jr; BranchEQ = v.beq; BranchNE = v.bne;
        id_mem_read = v.mr; id_reg_write = v.rw; id_uses_rt = v.urt;
        id_dst = v.dst; id_rs = v.rs; id_rt = v.rt; id_pc4 = v.pc4;
        rs_data = v.rsd; rt_data = v.rtd; id_imm16 = v.imm; id_jaddr = v.jaddr;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] p, input logic wr,
                            input logic fl, input logic bb, input logic [CW-1:0] sc,
                            input logic [CW-1:0] fc);
        chk({tag, ".pc"}, pc, p);
        chk({tag, ".if_id_write"}, 32'(if_id_write), 32'(wr));
        chk({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(fl));
        chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(bb));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(sc));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(fc));
    endtask

    initial begin
        vec_t multi;
        reset = 1'b1;
        drive(v_idle());

        // Expected values: pc during the cycle, write, flush, bubble, misalign, counters.
        tv.push_back(ex(v_idle(), 32'h0040_0000, 1, 0, 0, 0, 0, 0));
        tv.push_back(ex(v_idle(), 32'h0040_0004, 1, 0, 0, 0, 0, 0));
        tv.push_back(ex(v_idle(), 32'h0040_0008, 1, 0, 0, 0, 0, 0));
        tv.push_back(ex(v_lw(5'd8), 32'h0040_000C, 1, 0, 0, 0, 0, 0));
        tv.push_back(ex(v_alu(5'd8, 5'd9, 5'd10), 32'h0040_0010, 0, 0, 1, 0, 0, 0));
        tv.push_back(ex(v_alu(5'd8, 5'd9, 5'd10), 32'h0040_0010, 1, 0, 0, 0, 1, 0));
        tv.push_back(ex(v_br(0, 5'd1, 5'd2, 32'd5, 32'd5, 32'h0040_0010, 16'hFFFE),
                        32'h0040_0014, 1, 1, 0, 0, 1, 0));
        tv.push_back(ex(v_br(1, 5'd1, 5'd2, 32'd5, 32'd5, 32'h0040_0010, 16'hFFFE),
                        32'h0040_0008, 1, 0, 0, 0, 1, 1));
        tv.push_back(ex(v_idle(), 32'h0040_000C, 1, 0, 0, 0, 1, 1));
        tv.push_back(ex(v_lw(5'd9), 32'h0040_0010, 1, 0, 0, 0, 1, 1));
        for (int k = 0; k < 3; k++) begin
            tv.push_back(ex(v_br(0, 5'd9, 5'd3, 32'd7, 32'd7, 32'h0040_0020, 16'h0004),
                            32'h0040_0014, k == 2, k == 2, k != 2, 0, CW'(1 + k), 1));
        end
        tv.push_back(ex(v_jr(5'd4, 32'h0040_0033), 32'h0040_0030, 1, 1, 0, 0, 3, 2));
        tv.push_back(ex(v_jal(26'h010_0010, 32'h0040_0004), 32'h0040_0030, 1, 1, 0, 1, 3, 3));
        tv.push_back(ex(v_idle(), 32'h0040_0040, 1, 0, 0, 0, 3, 4));
        multi = v_br(0, 5'd5, 5'd6, 32'h0050_0000, 32'h0050_0000, 32'h0040_0048, 16'h0001);
        multi.jr = 1; multi.jump = 1; multi.jaddr = 26'h1;
        tv.push_back(ex(multi, 32'h0040_0044, 1, 1, 0, 0, 3, 4));
        tv.push_back(ex(v_idle(), 32'h0050_0000, 1, 0, 0, 0, 3, 5));
        tv.push_back(ex(v_alu(5'd1, 5'd2, 5'd12), 32'h0050_0004, 1, 0, 0, 0, 3, 5));
        tv.push_back(ex(v_jr(5'd12, 32'h0060_0000), 32'h0050_0008, 0, 0, 1, 0, 3, 5));
        tv.push_back(ex(v_jr(5'd12, 32'h0060_0000), 32'h0050_0008, 1, 1, 0, 0, 4, 5));
        tv.push_back(ex(v_idle(), 32'h0060_0000, 1, 0, 0, 0, 4, 6));
        tv.push_back(ex(v_lw(5'd0), 32'h0060_0004, 1, 0, 0, 0, 4, 6));
        tv.push_back(ex(v_alu(5'd0, 5'd0, 5'd5), 32'h0060_0008, 1, 0, 0, 0, 4, 6));
        tv.push_back(ex(v_idle(), 32'h0060_000C, 1, 0, 0, 0, 4, 6));

        @(negedge clk);
        @(negedge clk);
        chk_outs("reset", RST_PC, 0, 1, 1, 0, 0);
        chk("reset.jr_misalign", 32'(jr_misalign), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            #1;
            chk_outs($sformatf("v%0d", i), tv[i].e_pc, tv[i].e_wr, tv[i].e_fl, tv[i].e_bb,
                     tv[i].e_sc, tv[i].e_fc);
            chk($sformatf("v%0d.jr_misalign", i), 32'(jr_misalign), 32'(tv[i].e_mis));
            @(negedge clk);
        end

        // Load then dependent not-taken branch: two stalls per four cycles until saturation.
        for (int q = 0; q < 140; q++) begin
            drive(v_lw(5'd9));
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                drive(v_br(0, 5'd9, 5'd3, 32'd1, 32'd2, 32'h0, 16'h0));
                @(negedge clk);
            end
        end
        drive(v_idle());
        #1;
        chk("sat.stall_cnt", 32'(stall_cnt), 32'hFF);
        chk("sat.flush_cnt", 32'(flush_cnt), 32'd6);

        // Reset asserted in the middle of a stall cycle.
        @(negedge clk);
        drive(v_lw(5'd9));
        @(negedge clk);
        drive(v_br(0, 5'd9, 5'd3, 32'd1, 32'd2, 32'h0, 16'h0));
        #1;
        chk("midstall.id_ex_bubble", 32'(id_ex_bubble), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_outs("midreset", RST_PC, 0, 1, 1, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_outs("postreset0", RST_PC, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(v_idle());
        #1;
        chk_outs("postreset1", 32'h0040_0004, 1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
